// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the character LCD sequencer
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWR,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } lcd_state_t;

  localparam int LP_TMR_W  = 20;

  localparam int LP_BIT_ON = 31;
  localparam int LP_BIT_EN = 10;
  localparam int LP_BIT_RS = 9;
  localparam int LP_BIT_RW = 8;

  localparam logic [7:0] LP_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LP_CMD_HOME     = 8'h02;
  localparam logic [7:0] LP_CMD_HOME_ALT = 8'h03;

  // Entry [0] is sent first: function set, display on, clear, entry mode.
  localparam logic [3:0][7:0] LP_INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LP_CMD_CLEAR || data == LP_CMD_HOME || data == LP_CMD_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// rtl/lcd_timer.sv - loadable down-counter; o_zero flags the last cycle of a state
module lcd_timer
  import lcd_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_load,
  input  logic [LP_TMR_W-1:0] i_value,
  output logic                o_zero
);

  logic [LP_TMR_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780 power-on, init sequence and timed single-transfer engine
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int P_POWERON  = 750000,
  parameter int P_SETUP    = 2,
  parameter int P_PULSE    = 12,
  parameter int P_HOLD     = 2,
  parameter int P_CMD_WAIT = 2000,
  parameter int P_CLR_WAIT = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_rs,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  output logic        o_init_done,
  output logic [31:0] o_io_lcd
);

  localparam logic [LP_TMR_W-1:0] LP_PWR_M1 = LP_TMR_W'(P_POWERON - 1);
  localparam logic [LP_TMR_W-1:0] LP_SET_M1 = LP_TMR_W'(P_SETUP - 1);
  localparam logic [LP_TMR_W-1:0] LP_PUL_M1 = LP_TMR_W'(P_PULSE - 1);
  localparam logic [LP_TMR_W-1:0] LP_HLD_M1 = LP_TMR_W'(P_HOLD - 1);
  localparam logic [LP_TMR_W-1:0] LP_CMD_M1 = LP_TMR_W'(P_CMD_WAIT - 1);
  localparam logic [LP_TMR_W-1:0] LP_CLR_M1 = LP_TMR_W'(P_CLR_WAIT - 1);

  lcd_state_t          r_state;
  logic [1:0]          r_idx;
  logic                r_init_done;
  logic                r_on;
  logic                r_en;
  logic                r_rs;
  logic [7:0]          r_data;

  logic                w_tmr_load;
  logic [LP_TMR_W-1:0] w_tmr_value;
  logic                w_tmr_zero;

  lcd_timer u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_zero  (w_tmr_zero)
  );

  // Load the timer on the same edge the FSM enters the timed state, so the
  // first cycle of that state already reads N-1.
  always_comb begin
    w_tmr_load  = 1'b0;
    w_tmr_value = '0;
    case (r_state)
      S_PWR: begin
        if (!r_on) begin
          w_tmr_load  = 1'b1;
          w_tmr_value = LP_PWR_M1;
        end
      end
      S_LOAD: begin
        w_tmr_load  = 1'b1;
        w_tmr_value = LP_SET_M1;
      end
      S_SETUP: begin
        w_tmr_load  = w_tmr_zero;
        w_tmr_value = LP_PUL_M1;
      end
      S_PULSE: begin
        w_tmr_load  = w_tmr_zero;
        w_tmr_value = LP_HLD_M1;
      end
      S_HOLD: begin
        w_tmr_load  = w_tmr_zero;
        w_tmr_value = is_slow_cmd(r_rs, r_data) ? LP_CLR_M1 : LP_CMD_M1;
      end
      S_IDLE: begin
        w_tmr_load  = i_valid;
        w_tmr_value = LP_SET_M1;
      end
      default: begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= S_PWR;
      r_idx       <= 2'd0;
      r_init_done <= 1'b0;
      r_on        <= 1'b0;
      r_en        <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      case (r_state)
        S_PWR: begin
          if (!r_on) begin
            r_on <= 1'b1;
          end else if (w_tmr_zero) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_rs    <= 1'b0;
          r_data  <= LP_INIT_ROM[r_idx];
          r_state <= S_SETUP;
        end
        S_SETUP: begin
          if (w_tmr_zero) begin
            r_en    <= 1'b1;
            r_state <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (w_tmr_zero) begin
            r_en    <= 1'b0;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_tmr_zero) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_tmr_zero) begin
            if (r_init_done) begin
              r_state <= S_IDLE;
            end else if (r_idx != 2'd3) begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_LOAD;
            end else begin
              r_init_done <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (i_valid) begin
            r_rs    <= i_rs;
            r_data  <= i_data;
            r_state <= S_SETUP;
          end
        end
        default: r_state <= S_PWR;
      endcase
    end
  end

  assign o_ready     = (r_state == S_IDLE);
  assign o_init_done = r_init_done;
  assign o_io_lcd    = {r_on, 20'h00000, r_en, r_rs, 1'b0, r_data};

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - directed bench for lcd_ctrl with short timing parameters
module tb_lcd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        rs = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        ready;
  logic        init_done;
  logic [31:0] io;

  int   total = 0;
  int   bad = 0;
  int   en_rises = 0;
  logic prev_en = 1'b0;
  int   n;
  int   base;

  logic [7:0] rom [4];

  lcd_ctrl #(
    .P_POWERON  (5),
    .P_SETUP    (2),
    .P_PULSE    (3),
    .P_HOLD     (1),
    .P_CMD_WAIT (4),
    .P_CLR_WAIT (9)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_valid     (valid),
    .i_rs        (rs),
    .i_data      (data),
    .o_ready     (ready),
    .o_init_done (init_done),
    .o_io_lcd    (io)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (io[10] === 1'b1 && prev_en === 1'b0) en_rises <= en_rises + 1;
    prev_en <= io[10];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic to_en(output int k);
    k = 0;
    while (io[10] !== 1'b1 && k < 500) begin tick; k++; end
  endtask

  task automatic en_width(output int k);
    k = 0;
    while (io[10] === 1'b1 && k < 500) begin tick; k++; end
  endtask

  task automatic to_ready(output int k);
    k = 0;
    while (ready !== 1'b1 && k < 500) begin tick; k++; end
  endtask

  // Called at the negedge where reset is released. Power-on lasts 5 cycles
  // after ON rises, S_LOAD 1, setup 2: first EN seen 8 samples later.
  // Rise-to-rise is pulse 3 + hold 1 + wait + load 1 + setup 2.
  task automatic init_seq(input string tag, input bit poke);
    base = en_rises;
    tick;
    chk({tag, "_on"}, io, 32'h8000_0000);
    to_en(n);
    chk({tag, "_first_en"}, n, 8);
    chk({tag, "_p0"}, io, 32'h8000_0438);
    en_width(n);
    chk({tag, "_w0"}, n, 3);
    if (poke) begin valid = 1'b1; rs = 1'b1; data = 8'h55; end
    for (int i = 1; i < 4; i++) begin
      to_en(n);
      chk($sformatf("%s_gap%0d", tag, i), n, (i == 3) ? 13 : 8);
      chk($sformatf("%s_p%0d", tag, i), io, 32'h8000_0400 | {24'h0, rom[i]});
      chk($sformatf("%s_rdy%0d", tag, i), {31'h0, ready}, 32'h0);
      if (i == 3) valid = 1'b0;
      en_width(n);
      chk($sformatf("%s_w%0d", tag, i), n, 3);
    end
    chk({tag, "_done_pre"}, {31'h0, init_done}, 32'h0);
    to_ready(n);
    chk({tag, "_ready_gap"}, n, 5);
    chk({tag, "_done"}, {31'h0, init_done}, 32'h1);
    chk({tag, "_rises"}, en_rises - base, 4);
  endtask

  // Acceptance edge falls in the first tick; EN at +2, falls at +5,
  // ready back at +gap, i.e. gap-5 samples after EN falls.
  task automatic xfer(input string tag, input logic r, input logic [7:0] d,
                      input logic [31:0] exp_en, input int gap);
    valid = 1'b1; rs = r; data = d;
    tick;
    valid = 1'b0;
    chk({tag, "_busy"}, {31'h0, ready}, 32'h0);
    to_en(n);
    chk({tag, "_setup"}, n, 2);
    chk({tag, "_en"}, io, exp_en);
    en_width(n);
    chk({tag, "_width"}, n, 3);
    to_ready(n);
    chk({tag, "_ready"}, n, gap - 5);
    chk({tag, "_idle_io"}, io, exp_en ^ 32'h0000_0400);
  endtask

  initial begin
    rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;

    tick; tick;
    chk("rst_io", io, 32'h0);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_done", {31'h0, init_done}, 32'h0);

    rst_n = 1'b1;
    init_seq("init", 1'b1);

    xfer("char_A", 1'b1, 8'h41, 32'h8000_0641, 10);

    base = en_rises;
    valid = 1'b1; rs = 1'b1; data = 8'h48;
    tick;
    chk("H_busy", {31'h0, ready}, 32'h0);
    to_en(n);
    chk("H_setup", n, 2);
    chk("H_en", io, 32'h8000_0648);
    en_width(n);
    chk("H_width", n, 3);
    to_ready(n);
    chk("H_ready", n, 5);
    data = 8'h69;
    tick;
    chk("i_busy", {31'h0, ready}, 32'h0);
    to_en(n);
    chk("i_setup", n, 2);
    chk("i_en", io, 32'h8000_0669);
    valid = 1'b0;
    en_width(n);
    chk("i_width", n, 3);
    to_ready(n);
    chk("i_ready", n, 5);
    repeat (20) tick;
    chk("Hi_rises", en_rises - base, 2);
    chk("Hi_idle", {31'h0, ready}, 32'h1);

    xfer("clear", 1'b0, 8'h01, 32'h8000_0401, 15);

    valid = 1'b1; rs = 1'b1; data = 8'h5A;
    tick;
    valid = 1'b0;
    to_en(n);
    chk("Z_setup", n, 2);
    chk("Z_en", io, 32'h8000_065A);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_io", io, 32'h0);
    chk("mid_rst_ready", {31'h0, ready}, 32'h0);
    chk("mid_rst_done", {31'h0, init_done}, 32'h0);
    tick;
    rst_n = 1'b1;
    init_seq("reinit", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
